// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared SPI definitions: engine state encoding, transfer
//               widths and the {cpol,cpha} mode encoding also used by
//               spi_clock_generator.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int SPI_DATA_W = 8;
    localparam int SPI_CNT_W  = 4;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    // Mode number is {cpol,cpha}
    typedef enum logic [1:0] {
        SPI_MODE0 = 2'b00,
        SPI_MODE1 = 2'b01,
        SPI_MODE2 = 2'b10,
        SPI_MODE3 = 2'b11
    } spi_mode_e;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_shift_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_shift_engine
// Description : Byte-wide SPI master shift engine. Consumes the clock
//               generator's SCLK level and sample/setup strobes, serialises
//               the TX byte onto MOSI, deserialises MISO, and raises the
//               SPIF/WCOL status flags. The generator is held in reset while
//               idle so every transfer starts phase-aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_mstr,
    input  logic              i_cpol,
    input  logic              i_cpha,
    input  logic              i_lsbfe,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_spif_clear,
    input  logic              i_sclk,
    input  logic              i_sample,
    input  logic              i_setup,
    input  logic              i_miso,
    output logic              o_gen_reset,
    output logic              o_sclk_pin,
    output logic              o_mosi,
    output logic              o_ss_n,
    output logic              o_busy,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_done,
    output logic              o_spif,
    output logic              o_wcol
);

    localparam logic [SPI_CNT_W-1:0] c_last_bit = SPI_CNT_W'(DATA_W - 1);
    localparam logic [SPI_CNT_W-1:0] c_all_bits = SPI_CNT_W'(DATA_W);

    spi_state_e            r_state;
    logic                  r_cpol;
    logic                  r_cpha;
    logic                  r_lsbfe;
    logic [DATA_W-1:0]     r_tx_sr;
    logic [DATA_W-1:0]     r_rx_sr;
    logic [SPI_CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0]     r_rx_data;
    logic                  r_done;
    logic                  r_spif;
    logic                  r_wcol;
    logic                  r_miso_meta;
    logic                  r_miso_sync;

    logic                  w_active;
    logic [DATA_W-1:0]     w_rx_next;
    logic [DATA_W-1:0]     w_tx_next;

    assign w_active  = (r_state == ST_ACTIVE);
    // RX fills from the end opposite to the one TX drains, keeping bit order
    assign w_rx_next = r_lsbfe ? {r_miso_sync, r_rx_sr[DATA_W-1:1]}
                               : {r_rx_sr[DATA_W-2:0], r_miso_sync};
    assign w_tx_next = r_lsbfe ? {1'b0, r_tx_sr[DATA_W-1:1]}
                               : {r_tx_sr[DATA_W-2:0], 1'b0};

    assign o_gen_reset = ~w_active;
    assign o_ss_n      = ~w_active;
    assign o_busy      = w_active;
    assign o_sclk_pin  = w_active ? (i_sclk ^ r_cpol) : i_cpol;
    assign o_mosi      = w_active & (r_lsbfe ? r_tx_sr[0] : r_tx_sr[DATA_W-1]);
    assign o_rx_data   = r_rx_data;
    assign o_done      = r_done;
    assign o_spif      = r_spif;
    assign o_wcol      = r_wcol;

    // Two-flop synchroniser for the asynchronous MISO input
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_miso_meta <= 1'b0;
            r_miso_sync <= 1'b0;
        end else begin
            r_miso_meta <= i_miso;
            r_miso_sync <= r_miso_meta;
        end
    end

    // Transfer FSM: shift registers, bit counter, completion and status flags
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_lsbfe   <= 1'b0;
            r_tx_sr   <= '0;
            r_rx_sr   <= '0;
            r_cnt     <= '0;
            r_rx_data <= '0;
            r_done    <= 1'b0;
            r_spif    <= 1'b0;
            r_wcol    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Clear first so a same-cycle set below takes priority
            if (i_spif_clear) begin
                r_spif <= 1'b0;
                r_wcol <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_start && i_mstr) begin
                        if (r_done) begin
                            // Completion cycle still counts as busy for writes
                            r_wcol <= 1'b1;
                        end else begin
                            r_state <= ST_ACTIVE;
                            r_tx_sr <= i_tx_data;
                            r_rx_sr <= '0;
                            r_cnt   <= '0;
                            r_cpol  <= i_cpol;
                            r_cpha  <= i_cpha;
                            r_lsbfe <= i_lsbfe;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (i_start && i_mstr) begin
                        r_wcol <= 1'b1;
                    end
                    if (i_sample) begin
                        r_rx_sr <= w_rx_next;
                        r_cnt   <= r_cnt + 1'b1;
                        // CPHA=1 ends on the last sample, including that bit
                        if (r_cpha && (r_cnt == c_last_bit)) begin
                            r_rx_data <= w_rx_next;
                            r_done    <= 1'b1;
                            r_spif    <= 1'b1;
                            r_state   <= ST_IDLE;
                        end
                    end else if (i_setup) begin
                        if (!r_cpha && (r_cnt == c_all_bits)) begin
                            // CPHA=0 ends on the trailing edge back to idle
                            r_rx_data <= r_rx_sr;
                            r_done    <= 1'b1;
                            r_spif    <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else if ((r_cnt != '0) && (r_cnt < c_all_bits)) begin
                            // Count 0 is the CPHA=1 leading edge: bit 0 already out
                            r_tx_sr <= w_tx_next;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : spi_shift_engine
`default_nettype wire

// File: tb/tb_spi_shift_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_spi_shift_engine
// Description : Self-checking bench for spi_shift_engine with a behavioural
//               clock generator, a slave model and a done-driven scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_shift_engine;
    import spi_pkg::*;

    localparam int HALF = 2;  // half SCLK period in i_clk cycles (divide 4)

    logic       clk = 1'b0;
    logic       rst;
    logic       mstr, cpol, cpha, lsbfe, start, spif_clear;
    logic [7:0] tx_data;
    logic       g_sclk, g_sample, g_setup;
    logic       miso;
    logic       gen_reset, sclk_pin, mosi, ss_n, busy, done, spif, wcol;
    logic [7:0] rx_data;

    logic [7:0] slave_byte;
    int         slave_idx;
    int         gcnt;
    int         g_edges;
    logic [7:0] cap_seq;
    int         ss_low_cycles;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] rx;
        logic [7:0] seq;
        logic       pol;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    spi_shift_engine #(.DATA_W(8)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_mstr       (mstr),
        .i_cpol       (cpol),
        .i_cpha       (cpha),
        .i_lsbfe      (lsbfe),
        .i_start      (start),
        .i_tx_data    (tx_data),
        .i_spif_clear (spif_clear),
        .i_sclk       (g_sclk),
        .i_sample     (g_sample),
        .i_setup      (g_setup),
        .i_miso       (miso),
        .o_gen_reset  (gen_reset),
        .o_sclk_pin   (sclk_pin),
        .o_mosi       (mosi),
        .o_ss_n       (ss_n),
        .o_busy       (busy),
        .o_rx_data    (rx_data),
        .o_done       (done),
        .o_spif       (spif),
        .o_wcol       (wcol)
    );

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    // Slave drives bit k after its k-th setup edge (CPHA=0) or k+1-th (CPHA=1)
    function automatic logic slave_bit(input logic [7:0] b, input int idx,
                                       input logic pha, input logic lsb);
        int k;
        k = pha ? idx - 1 : idx;
        if (k < 0) k = 0;
        if (k > 7) k = 7;
        return lsb ? b[k] : b[7-k];
    endfunction

    assign miso = slave_bit(slave_byte, slave_idx, cpha, lsbfe);

    // Behavioural clock generator: toggles SCLK every HALF cycles with strobes
    always @(posedge clk) begin
        if (rst || gen_reset) begin
            gcnt      <= 0;
            g_sclk    <= 1'b0;
            g_sample  <= 1'b0;
            g_setup   <= 1'b0;
            g_edges   <= 0;
            slave_idx <= 0;
        end else begin
            g_sample <= 1'b0;
            g_setup  <= 1'b0;
            if (gcnt == HALF - 1) begin
                gcnt    <= 0;
                g_sclk  <= ~g_sclk;
                g_edges <= g_edges + 1;
                if ((g_sclk == 1'b0) ^ cpha) begin
                    g_sample <= 1'b1;
                end else begin
                    g_setup   <= 1'b1;
                    slave_idx <= slave_idx + 1;
                end
            end else begin
                gcnt <= gcnt + 1;
            end
        end
    end

    // Capture MOSI at each sample strobe, and count SS_n-low cycles
    always @(negedge clk) begin
        if (gen_reset) cap_seq <= 8'h00;
        else if (g_sample) cap_seq <= {cap_seq[6:0], mosi};
        if (!ss_n) ss_low_cycles <= ss_low_cycles + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every o_done pops one expected transfer
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                e = sbq.pop_front();
                chk("rx_data",      32'(rx_data),   32'(e.rx));
                chk("mosi_seq",     32'(cap_seq),   32'(e.seq));
                chk("sclk_edges",   32'(g_edges),   16);
                chk("ss_n_at_done", 32'(ss_n),      1);
                chk("busy_at_done", 32'(busy),      0);
                chk("genrst_done",  32'(gen_reset), 1);
                chk("pin_at_done",  32'(sclk_pin),  32'(e.pol));
                chk("spif_at_done", 32'(spif),      1);
            end
        end
    end

    task automatic start_xfer(input logic pol, input logic pha, input logic lsb,
                              input logic [7:0] tx, input logic [7:0] slv,
                              input bit expect_done);
        exp_t e;
        @(negedge clk);
        cpol = pol; cpha = pha; lsbfe = lsb;
        slave_byte = slv; tx_data = tx; start = 1'b1;
        e.rx = slv; e.seq = lsb ? rev8(tx) : tx; e.pol = pol;
        if (expect_done) sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("ss_n_active", 32'(ss_n),      0);
        chk("gen_rst_low", 32'(gen_reset), 0);
        chk("first_mosi",  32'(mosi),      32'(lsb ? tx[0] : tx[7]));
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=0 required=1");
        end
    endtask

    task automatic clear_flags();
        @(negedge clk); spif_clear = 1'b1;
        @(negedge clk); spif_clear = 1'b0;
        chk("spif_cleared", 32'(spif), 0);
        chk("wcol_cleared", 32'(wcol), 0);
    endtask

    initial begin
        rst = 1'b1; mstr = 1'b1; cpol = 1'b0; cpha = 1'b0; lsbfe = 1'b0;
        start = 1'b0; spif_clear = 1'b0; tx_data = 8'h00; slave_byte = 8'h00;
        ss_low_cycles = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_gen_reset", 32'(gen_reset), 1);
        chk("rst_ss_n",      32'(ss_n),      1);
        chk("rst_busy",      32'(busy),      0);
        chk("rst_mosi",      32'(mosi),      0);
        chk("rst_rx_data",   32'(rx_data),   0);
        chk("rst_done",      32'(done),      0);
        chk("rst_spif",      32'(spif),      0);
        chk("rst_wcol",      32'(wcol),      0);

        // Master disabled: start must be ignored
        mstr = 1'b0; tx_data = 8'hFF; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (40) @(negedge clk);
        chk("nomstr_ss_low", 32'(ss_low_cycles), 0);
        chk("nomstr_edges",  32'(g_edges),       0);
        chk("nomstr_spif",   32'(spif),          0);
        chk("nomstr_wcol",   32'(wcol),          0);
        mstr = 1'b1;

        // Mode 0, MSB first
        start_xfer(1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C, 1'b1);
        wait_done();
        clear_flags();

        // Mode 3, LSB first; pin idles high before and after
        @(negedge clk); cpol = 1'b1; cpha = 1'b1;
        @(negedge clk);
        chk("mode3_pin_before", 32'(sclk_pin), 1);
        start_xfer(1'b1, 1'b1, 1'b1, 8'h81, 8'hF0, 1'b1);
        wait_done();
        @(negedge clk);
        chk("mode3_pin_after", 32'(sclk_pin), 1);
        clear_flags();

        // Mode 1: ends on the 8th (falling) sample edge
        start_xfer(1'b0, 1'b1, 1'b0, 8'h5A, 8'hA7, 1'b1);
        wait_done();
        clear_flags();

        // Write collision mid-transfer; first byte must complete unchanged
        start_xfer(1'b0, 1'b0, 1'b0, 8'h96, 8'h69, 1'b1);
        repeat (10) @(negedge clk);
        tx_data = 8'h55; start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("wcol_set",  32'(wcol), 1);
        chk("wcol_busy", 32'(busy), 1);
        wait_done();
        chk("wcol_sticky", 32'(wcol), 1);

        // Clear coincident with a new completion: SPIF stays set, WCOL clears
        start_xfer(1'b1, 1'b0, 1'b1, 8'h12, 8'hE4, 1'b1);
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 200 && !hit; i++) begin
                @(negedge clk);
                if (g_edges == 16 && (g_setup || g_sample)) hit = 1'b1;
            end
            if (!hit) begin
                checks++;
                failures++;
                $display("FAIL end_strobe_timeout actual=0 required=1");
            end
        end
        spif_clear = 1'b1;
        @(negedge clk); spif_clear = 1'b0;
        chk("prio_done", 32'(done), 1);
        chk("prio_spif", 32'(spif), 1);
        chk("prio_wcol", 32'(wcol), 0);
        clear_flags();

        // Reset after 3 bits, then a clean transfer
        start_xfer(1'b0, 1'b0, 1'b0, 8'h3C, 8'h99, 1'b0);
        begin
            int n = 0;
            for (int i = 0; i < 200 && n < 3; i++) begin
                @(negedge clk);
                if (g_sample) n++;
            end
            chk("abort_samples", 32'(n), 3);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_gen_reset", 32'(gen_reset), 1);
        chk("abort_ss_n",      32'(ss_n),      1);
        chk("abort_busy",      32'(busy),      0);
        chk("abort_mosi",      32'(mosi),      0);
        chk("abort_rx_data",   32'(rx_data),   0);
        chk("abort_done",      32'(done),      0);
        chk("abort_spif",      32'(spif),      0);
        start_xfer(1'b0, 1'b0, 1'b0, 8'hC3, 8'h5E, 1'b1);
        wait_done();

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_spi_shift_engine
`default_nettype wire
